// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one combinational ALU between NUM_REQ requesters.
// One operation in flight: IDLE grants, EXEC captures the ALU result, RESP holds it until taken.
module alu_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]      req_sel,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [1:0]                alu_select,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic [4:0]                alu_flags,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_out,
  output logic [4:0]                rsp_flags,
  output logic                      rsp_err,
  output logic                      busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]   rr_ptr_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [1:0]        op_sel_q;
  logic [ID_W-1:0]   op_id_q;
  logic [DATA_W-1:0] rsp_out_q;
  logic [4:0]        rsp_flags_q;
  logic              rsp_err_q;

  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   scan_id;
  logic [ID_W-1:0]   next_ptr;
  logic              div_zero;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_id = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_valid && req_valid[scan_id]) begin
        grant_valid = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  assign next_ptr = ID_W'((32'(grant_id) + 1) % NUM_REQ);
  assign div_zero = (op_sel_q == 2'b11) && (op_b_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_valid) begin
      req_ready[grant_id] = 1'b1;
    end
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      op_id_q     <= '0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (state_q == StIdle && grant_valid) begin
        op_a_q   <= req_a[32'(grant_id) * DATA_W +: DATA_W];
        op_b_q   <= req_b[32'(grant_id) * DATA_W +: DATA_W];
        op_sel_q <= req_sel[32'(grant_id) * 2 +: 2];
        op_id_q  <= grant_id;
        rr_ptr_q <= next_ptr;
      end
      if (state_q == StExec) begin
        // Divide by zero bypasses whatever the ALU produced.
        if (div_zero) begin
          rsp_out_q   <= '0;
          rsp_flags_q <= '0;
          rsp_err_q   <= 1'b1;
        end else begin
          rsp_out_q   <= alu_out;
          rsp_flags_q <= alu_flags;
          rsp_err_q   <= 1'b0;
        end
      end
    end
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_select = op_sel_q;
  assign rsp_id     = op_id_q;
  assign rsp_out    = rsp_out_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a small behavioural 4-bit ALU attached.
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_sel;
  logic [3:0]  req_ready;
  logic [3:0]  alu_a, alu_b;
  logic [1:0]  alu_select;
  logic [3:0]  alu_out;
  logic [4:0]  alu_flags;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_out;
  logic [4:0]  rsp_flags;
  logic        rsp_err, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rsp_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_rr_scheduler #(.NUM_REQ(4), .DATA_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU; divide by zero returns junk so interception is visible.
  logic [4:0] s5;
  logic [7:0] p8;
  logic       c_f, v_f;
  always_comb begin
    s5 = '0; p8 = '0; c_f = 1'b0; v_f = 1'b0; alu_out = '0;
    case (alu_select)
      2'b00: begin
        s5 = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = s5[3:0]; c_f = s5[4];
        v_f = (alu_a[3] == alu_b[3]) && (alu_out[3] != alu_a[3]);
      end
      2'b01: begin
        s5 = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out = s5[3:0]; c_f = s5[4];
        v_f = (alu_a[3] != alu_b[3]) && (alu_out[3] != alu_a[3]);
      end
      2'b10: begin
        p8 = {4'b0, alu_a} * {4'b0, alu_b};
        alu_out = p8[3:0]; c_f = |p8[7:4]; v_f = c_f;
      end
      default: begin
        if (alu_b != 0) alu_out = alu_a / alu_b;
        else begin alu_out = 4'hF; c_f = 1'b1; v_f = 1'b1; end
      end
    endcase
    alu_flags = {v_f, ~^alu_out, alu_out[3], c_f, alu_out == 4'd0};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] sel);
    req_a[i*4 +: 4]   = a;
    req_b[i*4 +: 4]   = b;
    req_sel[i*2 +: 2] = sel;
  endtask

  // Waits for a grant, checks it, then drops the granted request after the accept edge.
  task automatic grant_and_drop(input string tag, input int id);
    logic [3:0] seen = '0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      seen = req_ready;
    end
    check(tag, 32'(seen), 32'(4'b1 << id));
    @(posedge clk); #1;
    req_valid = req_valid & ~seen;
  endtask

  task automatic wait_rsp(input string tag, input int id, input logic [3:0] o,
                          input logic [4:0] f, input logic e);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_id"}, 32'(rsp_id), 32'(id));
      check({tag, "_out"}, 32'(rsp_out), 32'(o));
      check({tag, "_flags"}, 32'(rsp_flags), 32'(f));
      check({tag, "_err"}, 32'(rsp_err), 32'(e));
    end
    rsp_cyc = cyc;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Expected results for the fixed test-2 payloads.
  logic [3:0] exp_out [4]   = '{4'h7, 4'hF, 4'hF, 4'h4};
  logic [4:0] exp_flags [4] = '{5'b00000, 5'b01110, 5'b01100, 5'b00000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_cyc;
    int hits;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_status", 32'({rsp_valid, busy, rsp_err}), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_select}), 32'd0);
    check("rst_rsp", 32'({rsp_id, rsp_out, rsp_flags}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: single add from requester 0, latency two edges
    set_req(0, 4'd3, 4'd4, 2'b00);
    set_req(1, 4'd5, 4'd6, 2'b01);
    set_req(2, 4'd3, 4'd5, 2'b10);
    set_req(3, 4'd9, 4'd2, 2'b11);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'd1);
    check("t1_busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("t1_exec", 32'({busy, rsp_valid, req_ready}), 32'({1'b1, 1'b0, 4'b0}));
    check("t1_alu", 32'({alu_a, alu_b, alu_select}), 32'({4'd3, 4'd4, 2'b00}));
    @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp", 32'({rsp_id, rsp_out, rsp_flags, rsp_err}),
          32'({2'd0, 4'd7, 5'd0, 1'b0}));

    // 2: all requesters continuously valid, consumer always ready
    do_reset();
    req_valid = 4'b1111;
    last_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_rsp($sformatf("t2_%0d", n), n % 4, exp_out[n%4], exp_flags[n%4], 1'b0);
      if (n > 0) check($sformatf("t2_gap_%0d", n), 32'(rsp_cyc - last_cyc), 32'd3);
      last_cyc = rsp_cyc;
    end
    @(posedge clk); #1 req_valid = '0;

    // 3: divide by zero is intercepted (rr_ptr is 1 here)
    set_req(2, 4'd9, 4'd0, 2'b11);
    req_valid = 4'b0100;
    grant_and_drop("t3_grant", 2);
    wait_rsp("t3", 2, 4'd0, 5'd0, 1'b1);

    // 4: response held while consumer stalls; 8+8 wraps to zero
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(3, 4'd8, 4'd8, 2'b00);
    req_valid = 4'b1000;
    grant_and_drop("t4_grant", 3);
    wait_rsp("t4", 3, 4'd0, 5'b11011, 1'b0);
    @(posedge clk); #1 req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold_%0d", i),
            32'({rsp_valid, busy, req_ready, rsp_id, rsp_out, rsp_flags, rsp_err}),
            32'({1'b1, 1'b1, 4'b0, 2'd3, 4'd0, 5'b11011, 1'b0}));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    grant_and_drop("t4_next", 0);
    wait_rsp("t4_r0", 0, 4'd7, 5'd0, 1'b0);

    // 5: after a grant to 1, requesters 0 and 3 pending -> 3 then 0
    @(posedge clk); #1 req_valid = 4'b0010;
    grant_and_drop("t5_g1", 1);
    req_valid = 4'b1001;
    grant_and_drop("t5_g3", 3);
    grant_and_drop("t5_g0", 0);
    wait_rsp("t5_r0", 0, 4'd7, 5'd0, 1'b0);

    // 6: reset while executing discards the op and clears rr_ptr
    @(posedge clk); #1;
    set_req(2, 4'd3, 4'd5, 2'b10);
    req_valid = 4'b0100;
    grant_and_drop("t6_g2", 2);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t6_idle", 32'({busy, rsp_valid}), 32'd0);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    check("t6_no_rsp", 32'(hits), 32'd0);
    @(posedge clk); #1 req_valid = 4'b0011;
    grant_and_drop("t6_ptr0", 0);
    req_valid = '0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
